muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 41 ++++
 rtl/muldiv_if.sv | 27 ++
 rtl/muldiv_iter.sv | 49 ++++
 rtl/muldiv_unit.sv | 115 +++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and decode helpers for the multiply/divide unit.
package muldiv_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;
  localparam logic [5:0] FUNCT_MULT  = 6'd24;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_DIV   = 6'd26;
  localparam logic [5:0] FUNCT_DIVU  = 6'd27;

  localparam logic [5:0] LAST_STEP = 6'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  typedef struct packed {
    logic is_div;
    logic is_signed;
  } op_t;

  function automatic logic funct_valid(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

  function automatic op_t decode(input logic [5:0] f);
    op_t op;
    op.is_div    = (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    op.is_signed = (f == FUNCT_MULT) || (f == FUNCT_DIV);
    return op;
  endfunction

  // Magnitude of a two's complement value when signed handling is enabled.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
    return (en && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Pipeline-facing bus of the multiply/divide unit.
interface muldiv_if;
  import muldiv_pkg::*;

  logic        start;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, funct, rs_data, rt_data, rd_req, rd_sel,
    input  rd_data, busy, done, stall, hi, lo
  );

  modport slave (
    input  start, funct, rs_data, rt_data, rd_req, rd_sel,
    output rd_data, busy, done, stall, hi, lo
  );
endinterface

// File: rtl/muldiv_iter.sv
// Radix-2 iterative datapath: shift-add multiply or restoring divide on
// unsigned magnitudes. Multiply leaves the product in acc; divide leaves
// {remainder, quotient}.
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic [63:0] acc
);

  logic [31:0] operand;   // multiplicand (mul) or divisor (div)
  logic        mode_div;
  logic [32:0] add_sum;
  logic        sub_ok;
  logic [31:0] sub_rem;

  // Step arithmetic: the divide compares the 33-bit shifted partial remainder,
  // but a successful subtract always fits back into 32 bits.
  always_comb begin
    add_sum = {1'b0, acc[63:32]} + {1'b0, operand};
    sub_ok  = acc[63:31] >= {1'b0, operand};
    sub_rem = acc[62:31] - operand;
  end

  // Accumulator load and one radix-2 step per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      operand  <= '0;
      mode_div <= 1'b0;
    end else if (load) begin
      mode_div <= is_div;
      operand  <= is_div ? opb : opa;
      acc      <= {32'd0, is_div ? opa : opb};
    end else if (step) begin
      if (mode_div)
        acc <= sub_ok ? {sub_rem, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
      else
        acc <= acc[0] ? {add_sum, acc[31:1]} : {1'b0, acc[63:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit: control FSM, step counter, sign
// handling, architectural HI/LO and the pipeline handshake.
module muldiv_unit
  import muldiv_pkg::*;
(
  input logic      clk,
  input logic      rst,
  muldiv_if.slave  bus
);

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  op_t         op, req_op;
  logic        sign_a, sign_b, b_zero;
  logic [31:0] hi_q, lo_q;
  logic        done_q;
  logic        accept, step, busy;
  logic [63:0] acc;
  logic        neg_res;
  logic [63:0] prod;
  logic [31:0] quot, rem;

  // Request decode and operand magnitudes for the datapath load.
  always_comb req_op = decode(bus.funct);

  // Next-state logic; starts are only taken in IDLE with a valid funct.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      ST_IDLE: if (bus.start && funct_valid(bus.funct)) begin
        accept    = 1'b1;
        state_nxt = ST_CALC;
      end
      ST_CALC: begin
        step = 1'b1;
        if (cnt == LAST_STEP) state_nxt = ST_FIX;
      end
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Step counter, cleared on accept.
  always_ff @(posedge clk) begin
    if (rst || accept) cnt <= '0;
    else if (step)     cnt <= cnt + 6'd1;
  end

  // Operation and sign flags captured at start; later operand changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      op     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
    end else if (accept) begin
      op     <= req_op;
      sign_a <= bus.rs_data[31];
      sign_b <= bus.rt_data[31];
      b_zero <= (bus.rt_data == 32'd0);
    end
  end

  muldiv_iter u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (step),
    .is_div (req_op.is_div),
    .opa    (abs32(bus.rs_data, req_op.is_signed)),
    .opb    (abs32(bus.rt_data, req_op.is_signed)),
    .acc    (acc)
  );

  // Sign correction; a zero divisor forces LO to all ones while the remainder
  // naturally reproduces A.
  always_comb begin
    neg_res = op.is_signed & (sign_a ^ sign_b);
    prod    = neg_res ? (64'd0 - acc) : acc;
    quot    = b_zero ? 32'hFFFF_FFFF : (neg_res ? (32'd0 - acc[31:0]) : acc[31:0]);
    rem     = (op.is_signed & sign_a) ? (32'd0 - acc[63:32]) : acc[63:32];
  end

  // HI/LO only change on leaving FIX; done pulses in the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == ST_FIX);
      if (state == ST_FIX) begin
        if (op.is_div) {hi_q, lo_q} <= {rem, quot};
        else           {hi_q, lo_q} <= prod;
      end
    end
  end

  assign busy        = (state != ST_IDLE);
  assign bus.busy    = busy;
  assign bus.done    = done_q;
  assign bus.stall   = busy & bus.rd_req;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected {HI,LO}, a
// negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [63:0] exp_q[$];
  int          cyc_q[$];
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the architectural rules.
  function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      FUNCT_MULT:  return 64'(sa * sb);
      FUNCT_MULTU: return ua * ub;
      FUNCT_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Scoreboard monitor: latency, result, rd_data mux and HI/LO hold.
  always @(negedge clk) begin
    logic [63:0] e;
    int          sc;
    if (rst) begin
      last_hi = '0;
      last_lo = '0;
    end else if (bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e  = exp_q.pop_front();
        sc = cyc_q.pop_front();
        // done is seen in the cycle after edge start+33, i.e. sampled at start+34
        chk("latency", 64'(cyc - sc + 1), 64'd34);
        chk("hi", {32'd0, bus.hi}, {32'd0, e[63:32]});
        chk("lo", {32'd0, bus.lo}, {32'd0, e[31:0]});
        chk("rd_data", {32'd0, bus.rd_data}, {32'd0, bus.rd_sel ? e[63:32] : e[31:0]});
        chk("busy_in_done", {63'd0, bus.busy}, 64'd0);
        last_hi = e[63:32];
        last_lo = e[31:0];
      end
    end else begin
      chk("hilo_hold", {bus.hi, bus.lo}, {last_hi, last_lo});
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 200);
    if (bus.busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  // Issue one op right after an idle negedge; operands are scrambled after the start edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_result);
    wait_idle();
    #1;
    bus.start = 1'b1; bus.funct = f; bus.rs_data = a; bus.rt_data = b;
    @(posedge clk);
    #1;
    if (expect_result) begin
      exp_q.push_back(ref_result(f, a, b));
      cyc_q.push_back(cyc);
    end
    bus.start = 1'b0;
    bus.funct = 6'($urandom);
    bus.rs_data = $urandom;
    bus.rt_data = $urandom;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start = 1'b0; bus.funct = '0; bus.rs_data = '0; bus.rt_data = '0;
    bus.rd_req = 1'b1; bus.rd_sel = 1'b1;

    // Reset state, with a pending read to show stall stays low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_stall", {63'd0, bus.stall}, 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    #1 rst = 1'b0;
    bus.rd_req = 1'b0;

    // Directed cases, issued back to back.
    issue(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    issue(FUNCT_MULT,  32'hFFFF_FFFD, 32'd5, 1);
    issue(FUNCT_DIV,   32'hFFFF_FFF9, 32'd2, 1);
    issue(FUNCT_DIVU,  32'd7, 32'd0, 1);
    issue(FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(FUNCT_DIV,   32'hFFFF_FFFB, 32'd0, 1);
    issue(FUNCT_DIV,   32'd7, 32'hFFFF_FFFE, 1);

    // Stall covers CALC and FIX, clears in the done cycle.
    bus.rd_req = 1'b1; bus.rd_sel = 1'b1;
    issue(FUNCT_MULT, 32'h1234_5678, 32'h8765_4321, 1);
    for (int k = 0; k <= 33; k++) begin
      @(negedge clk);
      chk($sformatf("stall_k%0d", k), {63'd0, bus.stall}, {63'd0, (k <= 32)});
    end
    bus.rd_req = 1'b0;

    // A start while busy is dropped: only the DIVU completes.
    issue(FUNCT_DIVU, 32'd100, 32'd7, 1);
    repeat (4) @(posedge clk);
    #1 bus.start = 1'b1; bus.funct = FUNCT_MULTU; bus.rs_data = 32'd2; bus.rt_data = 32'd2;
    @(posedge clk);
    #1 bus.start = 1'b0;

    // Invalid funct is ignored.
    wait_idle();
    #1 bus.start = 1'b1; bus.funct = FUNCT_MFHI; bus.rs_data = 32'd3; bus.rt_data = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("invalid_funct_busy", {63'd0, bus.busy}, 64'd0);

    // Reset mid-CALC discards the operation.
    bus.rd_req = 1'b1;
    issue(FUNCT_MULTU, 32'd9, 32'd9, 0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
    chk("midrst_stall", {63'd0, bus.stall}, 64'd0);
    chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    #1 rst = 1'b0;
    bus.rd_req = 1'b0;
    repeat (40) @(negedge clk);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      bus.rd_sel = 1'($urandom);
      issue(6'(24 + $urandom_range(0, 3)), pick(), pick(), 1);
    end

    // Drain the scoreboard, then watch for stray done pulses.
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
